// File: rtl/dmem_ctrl_pkg.sv
// Shared types, widths and instruction field layout for the data_mem controller.
`ifndef DMEM_CTRL_DEFINES
`define DMEM_CTRL_DEFINES
`define DATA_WIDTH 16
`define INST_WIDTH 32
`endif

package dmem_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int WADDR_LSB  = 16;
  localparam int RADDR1_LSB = 8;
  localparam int RADDR0_LSB = 0;
  localparam int FIELD_W    = 8;

  typedef logic [FIELD_W-1:0] field_t;

  // Unused instruction bits are always zero.
  function automatic logic [`INST_WIDTH-1:0] pack_inst(field_t waddr, field_t raddr1, field_t raddr0);
    logic [`INST_WIDTH-1:0] inst;
    inst = '0;
    inst[WADDR_LSB  +: FIELD_W] = waddr;
    inst[RADDR1_LSB +: FIELD_W] = raddr1;
    inst[RADDR0_LSB +: FIELD_W] = raddr0;
    return inst;
  endfunction

endpackage

// File: rtl/data_mem.sv
// Dual-read, single-write word memory driven by the packed dmem instruction.
module data_mem
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       wren,
  input  logic                       rden,
  input  logic [`INST_WIDTH-1:0]     inst,
  input  logic [`DATA_WIDTH*2-1:0]   wdata,
  output logic [`DATA_WIDTH*2-1:0]   rdata0,
  output logic [`DATA_WIDTH*2-1:0]   rdata1
);

  localparam int IAW = $clog2(DEPTH);

  logic [`DATA_WIDTH*2-1:0] mem [DEPTH];
  field_t waddr, raddr1, raddr0;
  logic   unused_bits;

  assign waddr       = inst[WADDR_LSB  +: FIELD_W];
  assign raddr1      = inst[RADDR1_LSB +: FIELD_W];
  assign raddr0      = inst[RADDR0_LSB +: FIELD_W];
  assign unused_bits = ^inst[`INST_WIDTH-1:WADDR_LSB+FIELD_W];

  // Read data is registered, so it is valid the cycle after rden.
  always_ff @(posedge clk) begin
    if (wren) mem[waddr[IAW-1:0]] <= wdata;
    if (rden) begin
      rdata0 <= mem[raddr0[IAW-1:0]];
      rdata1 <= mem[raddr1[IAW-1:0]];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Job controller: streams 2*npairs words into data_mem, then reads them back as pairs.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [AW-1:0]              npairs,
  input  logic                       abort,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [`DATA_WIDTH*2-1:0]   in_data,
  output logic                       out_valid,
  output logic [`DATA_WIDTH*2-1:0]   out_data0,
  output logic [`DATA_WIDTH*2-1:0]   out_data1,
  output logic                       busy,
  output logic                       done,
  output logic                       dmem_wren,
  output logic                       dmem_rden,
  output logic [`INST_WIDTH-1:0]     dmem_inst,
  output logic [`DATA_WIDTH*2-1:0]   dmem_wdata,
  input  logic [`DATA_WIDTH*2-1:0]   dmem_rdata0,
  input  logic [`DATA_WIDTH*2-1:0]   dmem_rdata1
);

  if (DEPTH > (1 << AW) || DEPTH < 2) begin : g_depth_check
    $error("dmem_ctrl: DEPTH must be between 2 and 2**AW");
  end

  localparam int            HALF_I    = DEPTH / 2;
  localparam logic [AW:0]   MAX_PAIRS = HALF_I[AW:0];

  state_t      state, next_state;
  logic [AW:0] npairs_q, npairs_sat, total, wcnt, rcnt;
  logic [AW:0] raddr0, raddr1;
  logic        load_hs;

  assign npairs_sat = ({1'b0, npairs} > MAX_PAIRS) ? MAX_PAIRS : {1'b0, npairs};
  assign total      = npairs_q << 1;
  assign raddr0     = {rcnt[AW-1:0], 1'b0};
  assign raddr1     = {rcnt[AW-1:0], 1'b1};

  // Read data lines are only meaningful in the cycle after a read.
  assign out_data0 = out_valid ? dmem_rdata0 : '0;
  assign out_data1 = out_valid ? dmem_rdata1 : '0;

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    load_hs    = 1'b0;
    dmem_wren  = 1'b0;
    dmem_rden  = 1'b0;
    dmem_inst  = '0;
    dmem_wdata = '0;
    done       = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (start && npairs != '0) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        load_hs  = in_valid && !abort;
        if (load_hs) begin
          dmem_wren  = 1'b1;
          dmem_wdata = in_data;
          dmem_inst  = pack_inst(field_t'(wcnt), '0, '0);
          if (wcnt == total - 1'b1) next_state = ST_READ;
        end
      end
      ST_READ: begin
        dmem_rden = 1'b1;
        dmem_inst = pack_inst('0, field_t'(raddr1), field_t'(raddr0));
        if (rcnt == npairs_q - 1'b1) next_state = ST_DRAIN;
      end
      ST_DRAIN: next_state = ST_DONE;
      ST_DONE: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
    // Abort beats every other transition, including the normal DONE exit.
    if (abort && state != ST_IDLE) next_state = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      npairs_q  <= '0;
      wcnt      <= '0;
      rcnt      <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= next_state;
      out_valid <= dmem_rden;
      if (state == ST_IDLE && next_state == ST_LOAD) begin
        npairs_q <= npairs_sat;
        wcnt     <= '0;
        rcnt     <= '0;
      end
      if (load_hs) wcnt <= wcnt + 1'b1;
      if (state == ST_READ) rcnt <= rcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench: dmem_ctrl wired to data_mem, expected writes and pairs queued at stimulus time.
module tb_dmem_ctrl;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int DW    = `DATA_WIDTH * 2;
  localparam int IW    = `INST_WIDTH;

  typedef struct packed {
    logic [7:0]    addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
  } pair_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] npairs = '0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, busy, done, dmem_wren, dmem_rden;
  logic [DW-1:0] out_data0, out_data1, dmem_wdata, dmem_rdata0, dmem_rdata1;
  logic [IW-1:0] dmem_inst;

  dmem_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .npairs(npairs), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_data0(out_data0), .out_data1(out_data1),
    .busy(busy), .done(done), .dmem_wren(dmem_wren), .dmem_rden(dmem_rden),
    .dmem_inst(dmem_inst), .dmem_wdata(dmem_wdata),
    .dmem_rdata0(dmem_rdata0), .dmem_rdata1(dmem_rdata1)
  );

  data_mem #(.DEPTH(DEPTH)) mem (
    .clk(clk), .wren(dmem_wren), .rden(dmem_rden), .inst(dmem_inst),
    .wdata(dmem_wdata), .rdata0(dmem_rdata0), .rdata1(dmem_rdata1)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;
  wr_t   wr_q[$];
  pair_t out_q[$];
  wr_t   mon_w;
  pair_t mon_p;
  int rd_idx = 0, wr_count = 0, ov_count = 0, done_count = 0;
  int first_ov = -1, last_ov = -1, done_cycle = -1;

  always @(posedge clk) cycle++;

  // Scoreboard: every write, read issue and output pair is checked as it appears.
  always @(negedge clk) begin
    if (dmem_wren) begin
      wr_count++;
      tests_run++;
      if (wr_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_write: addr=%0d data=%h, required no write", dmem_inst[23:16], dmem_wdata);
      end else begin
        mon_w = wr_q.pop_front();
        if (dmem_inst[23:16] !== mon_w.addr || dmem_wdata !== mon_w.data || dmem_inst[15:0] !== 16'h0) begin
          tests_failed++;
          $display("[TB] FAIL write: inst=%h data=%h, required addr=%0d data=%h", dmem_inst, dmem_wdata, mon_w.addr, mon_w.data);
        end
      end
    end
    if (dmem_rden) begin
      tests_run++;
      if (dmem_inst[7:0] !== 8'(2*rd_idx) || dmem_inst[15:8] !== 8'(2*rd_idx+1) || dmem_inst[23:16] !== 8'h0) begin
        tests_failed++;
        $display("[TB] FAIL read_issue: inst=%h, required raddr0=%0d raddr1=%0d", dmem_inst, 2*rd_idx, 2*rd_idx+1);
      end
      rd_idx++;
    end
    if (out_valid) begin
      ov_count++;
      if (first_ov < 0) first_ov = cycle;
      last_ov = cycle;
      tests_run++;
      if (out_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_out: got (%h,%h), required no out_valid", out_data0, out_data1);
      end else begin
        mon_p = out_q.pop_front();
        if (out_data0 !== mon_p.d0 || out_data1 !== mon_p.d1) begin
          tests_failed++;
          $display("[TB] FAIL out_pair: got (%h,%h), required (%h,%h)", out_data0, out_data1, mon_p.d0, mon_p.d1);
        end
      end
    end
    if (done) begin
      done_count++;
      done_cycle = cycle;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [DW-1:0] word_val(int base, int stride, int i);
    return DW'(base + stride * i);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pairs(int np, int base, int stride);
    pair_t p;
    for (int k = 0; k < np; k++) begin
      p.d0 = word_val(base, stride, 2*k);
      p.d1 = word_val(base, stride, 2*k+1);
      out_q.push_back(p);
    end
  endtask

  task automatic start_job(int np);
    rd_idx = 0; wr_count = 0; ov_count = 0;
    first_ov = -1; last_ov = -1; done_cycle = -1;
    start = 1'b1;
    npairs = AW'(np);
    #1;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL busy_start_cycle: busy=%b, required 0", busy);
    end
    step();
    start = 1'b0;
  endtask

  task automatic stream_words(int n, int base, int stride, bit toggle, int abort_at, int midstart_at);
    wr_t w;
    int  i = 0;
    bit  gap = 1'b0;
    while (i < n) begin
      if (gap) begin
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL in_ready_stall: in_ready=%b, required 1", in_ready);
        end
        step();
        gap = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = word_val(base, stride, i);
        if (i == abort_at) abort = 1'b1;
        else begin
          w.addr = 8'(i);
          w.data = in_data;
          wr_q.push_back(w);
        end
        if (i == midstart_at) begin
          start  = 1'b1;
          npairs = AW'(5);
        end
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL load_word%0d: in_ready=%b busy=%b, required 1 1", i, in_ready, busy);
        end
        step();
        in_valid = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        if (i == abort_at) return;
        i++;
        gap = toggle;
      end
    end
    tests_run++;
    if (in_ready !== 1'b0 || dmem_rden !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL load_end: in_ready=%b rden=%b, required 0 1", in_ready, dmem_rden);
    end
  endtask

  task automatic wait_done(int bound);
    int busy_bad = 0;
    bit got = 1'b0;
    for (int c = 0; c < bound; c++) begin
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("[TB] FAIL done_timeout: no done within %0d cycles, required done", bound);
    end
    tests_run++;
    if (busy_bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL busy_span: %0d cycles with busy low, required 0", busy_bad);
    end
    step();
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || dmem_inst !== '0) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_done: busy=%b done=%b in_ready=%b inst=%h, required all 0", busy, done, in_ready, dmem_inst);
    end
  endtask

  task automatic check_job_end(string name, int np);
    tests_run++;
    if (wr_count != 2*np || ov_count != np || wr_q.size() != 0 || out_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL %s_counts: writes=%0d outs=%0d pending=%0d/%0d, required %0d %0d 0/0",
               name, wr_count, ov_count, wr_q.size(), out_q.size(), 2*np, np);
    end
  endtask

  task automatic test_reset();
    start = 1'b1; npairs = AW'(3); in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    #2 rst = 1'b0;
    step();
    step();
    tests_run++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: in_ready=%b busy=%b done=%b, required 0 0 0", in_ready, busy, done);
    end
    tests_run++;
    if (dmem_wren !== 1'b0 || dmem_rden !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_en: wren=%b rden=%b out_valid=%b, required 0 0 0", dmem_wren, dmem_rden, out_valid);
    end
    tests_run++;
    if (dmem_inst !== '0 || dmem_wdata !== '0 || out_data0 !== '0 || out_data1 !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: inst=%h wdata=%h out=(%h,%h), required all 0", dmem_inst, dmem_wdata, out_data0, out_data1);
    end
    start = 1'b0; in_valid = 1'b0; in_data = '0;
    rst = 1'b1;
    step();
  endtask

  task automatic test_zero_start();
    start = 1'b1; npairs = '0;
    step();
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL zero_start: busy=%b in_ready=%b, required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    start_job(3);
    push_pairs(3, 1, 2);
    stream_words(6, 1, 2, 1'b0, -1, -1);
    wait_done(20);
    check_job_end("back_to_back", 3);
    tests_run++;
    if (last_ov - first_ov != 2 || done_cycle != last_ov + 1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_timing: first_ov=%0d last_ov=%0d done=%0d, required consecutive outs and done=last+1",
               first_ov, last_ov, done_cycle);
    end
  endtask

  task automatic test_toggle();
    start_job(3);
    push_pairs(3, 1, 2);
    stream_words(6, 1, 2, 1'b1, -1, -1);
    wait_done(20);
    check_job_end("toggle", 3);
  endtask

  task automatic test_single();
    start_job(1);
    push_pairs(1, 'hA, 1);
    stream_words(2, 'hA, 1, 1'b0, -1, -1);
    wait_done(10);
    check_job_end("single", 1);
  endtask

  task automatic test_abort();
    int done_before = done_count;
    start_job(3);
    stream_words(6, 'h100, 1, 1'b0, 2, -1);
    tests_run++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_idle: busy=%b in_ready=%b, required 0 0", busy, in_ready);
    end
    for (int c = 0; c < 5; c++) step();
    tests_run++;
    if (done_count != done_before || wr_count != 2 || wr_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL abort_effects: done_pulses=%0d writes=%0d pending=%0d, required 0 2 0",
               done_count - done_before, wr_count, wr_q.size());
    end
    start_job(2);
    push_pairs(2, 'h200, 3);
    stream_words(4, 'h200, 3, 1'b0, -1, -1);
    wait_done(15);
    check_job_end("after_abort", 2);
  endtask

  task automatic test_reset_mid_read();
    int done_before = done_count;
    start_job(3);
    stream_words(6, 'h300, 1, 1'b0, -1, -1);
    step();
    rst = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || dmem_wren !== 1'b0 || dmem_rden !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_ctrl: ov=%b done=%b busy=%b rdy=%b wren=%b rden=%b, required all 0",
               out_valid, done, busy, in_ready, dmem_wren, dmem_rden);
    end
    tests_run++;
    if (dmem_inst !== '0 || dmem_wdata !== '0 || out_data0 !== '0 || out_data1 !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_data: inst=%h wdata=%h out=(%h,%h), required all 0", dmem_inst, dmem_wdata, out_data0, out_data1);
    end
    step();
    step();
    rst = 1'b1;
    for (int c = 0; c < 10; c++) step();
    tests_run++;
    if (ov_count != 0 || done_count != done_before) begin
      tests_failed++;
      $display("[TB] FAIL midreset_after: out_valids=%0d done_pulses=%0d, required 0 0", ov_count, done_count - done_before);
    end
  endtask

  task automatic test_full_depth();
    start_job(128);
    push_pairs(128, 'h1000, 7);
    stream_words(256, 'h1000, 7, 1'b0, -1, 60);
    wait_done(300);
    check_job_end("full_depth", 128);
  endtask

  task automatic test_saturate();
    start_job(255);
    push_pairs(128, 'h5A00, 3);
    stream_words(256, 'h5A00, 3, 1'b0, -1, -1);
    wait_done(300);
    check_job_end("saturate", 128);
  endtask

  initial begin
    test_reset();
    test_zero_start();
    test_back_to_back();
    test_toggle();
    test_single();
    test_abort();
    test_reset_mid_read();
    test_full_depth();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
